apu_frame_counter: RTL and testbench

- APU frame sequencer on the CPU bus, downstream of the core/OAM-DMA wrapper.
- Snoops the wrapper's bus outputs (address, write data, rdwr, phy2) and decodes writes to $4017.
- Times quarter-frame and half-frame pulses for the APU channel units.
- Raises the frame IRQ that feeds back into the core's IRQ input.
- Provides the frame-IRQ bit for $4015 reads.

---
 rtl/apu_pkg.sv | 26 ++
 rtl/apu_frame_counter_phy2_edge.sv | 22 ++
 rtl/apu_frame_counter.sv | 146 ++++++++++++++
 tb/tb_apu_frame_counter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// apu_pkg: frame-sequencer mode type, NTSC/PAL step tables and APU register addresses.
package apu_pkg;

    typedef enum logic {
        frame_4step = 1'b0,
        frame_5step = 1'b1
    } frame_mode_type;

    // NTSC sequencer steps, in CPU cycles
    localparam int NTSC_STEP1 = 7457;
    localparam int NTSC_STEP2 = 14913;
    localparam int NTSC_STEP3 = 22371;
    localparam int NTSC_STEP4 = 29829;
    localparam int NTSC_STEP5 = 37281;

    // PAL sequencer steps, in CPU cycles
    localparam int PAL_STEP1 = 8313;
    localparam int PAL_STEP2 = 16627;
    localparam int PAL_STEP3 = 24939;
    localparam int PAL_STEP4 = 33253;
    localparam int PAL_STEP5 = 41565;

    localparam logic [15:0] APU_STATUS_ADDR = 16'h4015;
    localparam logic [15:0] APU_FRAME_ADDR  = 16'h4017;

endpackage

// File: rtl/apu_frame_counter_phy2_edge.sv
// phy2_edge: edge detector for the CPU phase-2 clock. The previous phy2 level is
// registered; the edges are that register compared with the live input.
module phy2_edge (
    input  logic I_clock,
    input  logic I_reset,
    input  logic I_phy2,
    output logic O_fall,
    output logic O_rise
);

    logic last_phy2;

    // Remember phy2 from the previous system clock
    always_ff @(posedge I_clock) begin
        if (I_reset) last_phy2 <= 1'b0;
        else         last_phy2 <= I_phy2;
    end

    assign O_fall = last_phy2 & ~I_phy2;
    assign O_rise = ~last_phy2 & I_phy2;

endmodule

// File: rtl/apu_frame_counter.sv
// apu_frame_counter: APU frame sequencer. Snoops the CPU bus for $4017 writes and
// $4015 reads, emits quarter/half-frame pulses and the frame IRQ.
// Build option: define APU_FRAME_PAL_EN to replace the step parameters with PAL timing.
module apu_frame_counter
    import apu_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int STEP1 = NTSC_STEP1,
    parameter int STEP2 = NTSC_STEP2,
    parameter int STEP3 = NTSC_STEP3,
    parameter int STEP4 = NTSC_STEP4,
    parameter int STEP5 = NTSC_STEP5
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic [15:0] I_addr,
    input  logic [7:0]  I_wr_data,
    input  logic        I_rdwr,
    input  logic        I_phy2,
    output logic        O_irq,
    output logic        O_quarter,
    output logic        O_half,
    output logic        O_rd_en,
    output logic [7:0]  O_rd_data
);

`ifdef APU_FRAME_PAL_EN
    localparam int P1 = PAL_STEP1;
    localparam int P2 = PAL_STEP2;
    localparam int P3 = PAL_STEP3;
    localparam int P4 = PAL_STEP4;
    localparam int P5 = PAL_STEP5;
`else
    localparam int P1 = STEP1;
    localparam int P2 = STEP2;
    localparam int P3 = STEP3;
    localparam int P4 = STEP4;
    localparam int P5 = STEP5;
`endif

    localparam logic [CNT_W-1:0] C1   = CNT_W'(P1);
    localparam logic [CNT_W-1:0] C2   = CNT_W'(P2);
    localparam logic [CNT_W-1:0] C3   = CNT_W'(P3);
    localparam logic [CNT_W-1:0] C4   = CNT_W'(P4);
    localparam logic [CNT_W-1:0] C4M1 = CNT_W'(P4 - 1);
    localparam logic [CNT_W-1:0] C5   = CNT_W'(P5);

    logic             tick;
    logic             unused_phy2_rise;
    logic             unused_wr_bits;

    logic [CNT_W-1:0] count;
    frame_mode_type   mode;
    frame_mode_type   new_mode;
    logic             inhibit;
    logic             irq_flag;
    logic             parity;
    logic [2:0]       dly;        // ticks left until a $4017 write takes effect; 0 = idle

    logic [CNT_W-1:0] fin;
    logic [CNT_W-1:0] cnt_nat;
    logic             wr_frame;
    logic             rd_status;
    logic             wrap;
    logic             expire;
    logic             inh_eff;
    logic             irq_set;
    logic             irq_clr;
    logic             q_nat;
    logic             h_nat;

    phy2_edge u_phy2_edge (
        .I_clock (I_clock),
        .I_reset (I_reset),
        .I_phy2  (I_phy2),
        .O_fall  (tick),
        .O_rise  (unused_phy2_rise)
    );

    // Only mode and inhibit bits of the $4017 write are meaningful here
    assign unused_wr_bits = ^I_wr_data[5:0];

    // Decode the bus and work out what the running sequence does on this tick
    always_comb begin
        wr_frame  = (I_addr == APU_FRAME_ADDR) && !I_rdwr;
        rd_status = (I_addr == APU_STATUS_ADDR) && I_rdwr;
        fin       = (mode == frame_5step) ? C5 : C4;
        wrap      = (count == fin);
        cnt_nat   = wrap ? '0 : count + 1'b1;
        q_nat     = (cnt_nat == C1) || (cnt_nat == C2) || (cnt_nat == C3) || (cnt_nat == fin);
        h_nat     = (cnt_nat == C2) || (cnt_nat == fin);
        // A write's inhibit bit already gates the IRQ on the write tick itself
        inh_eff   = wr_frame ? I_wr_data[6] : inhibit;
        irq_set   = (mode == frame_4step) && !inh_eff &&
                    ((cnt_nat == C4M1) || (cnt_nat == C4) || wrap);
        irq_clr   = rd_status || (wr_frame && I_wr_data[6]);
        expire    = (dly == 3'd1);
    end

    // Sequencer state machine: count, mode, delayed $4017 restart, IRQ and pulses
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            count     <= '0;
            mode      <= frame_4step;
            new_mode  <= frame_4step;
            inhibit   <= 1'b0;
            irq_flag  <= 1'b0;
            parity    <= 1'b0;
            dly       <= 3'd0;
            O_quarter <= 1'b0;
            O_half    <= 1'b0;
        end else begin
            O_quarter <= 1'b0;
            O_half    <= 1'b0;
            if (tick) begin
                parity   <= ~parity;
                // Set beats clear when both land on the same tick
                irq_flag <= irq_set | (irq_flag & ~irq_clr);
                // A new write restarts the delay; expiry below still uses the old latch
                if (wr_frame) begin
                    inhibit  <= I_wr_data[6];
                    new_mode <= frame_mode_type'(I_wr_data[7]);
                    dly      <= parity ? 3'd4 : 3'd3;
                end else if (dly != 3'd0) begin
                    dly <= dly - 3'd1;
                end
                // Expiry overrides the running sequence, including its final step
                if (expire) begin
                    count     <= '0;
                    mode      <= new_mode;
                    O_quarter <= (new_mode == frame_5step);
                    O_half    <= (new_mode == frame_5step);
                end else begin
                    count     <= cnt_nat;
                    O_quarter <= q_nat;
                    O_half    <= h_nat;
                end
            end
        end
    end

    assign O_irq     = irq_flag;
    assign O_rd_en   = (I_addr == APU_STATUS_ADDR) && I_rdwr && I_phy2;
    assign O_rd_data = {1'b0, irq_flag, 6'b0};

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter: short step values keep runs small; a tick-indexed
// reference model checks every CPU cycle, with targeted sequences for the corners.
module tb_apu_frame_counter;

`ifdef APU_FRAME_PAL_EN
    localparam int S1 = 8313, S2 = 16627, S3 = 24939, S4 = 33253, S5 = 41565;
`else
    localparam int S1 = 20, S2 = 41, S3 = 61, S4 = 82, S5 = 102;
`endif

    logic        I_clock = 1'b0;
    logic        I_reset = 1'b1;
    logic [15:0] I_addr = 16'h0000;
    logic [7:0]  I_wr_data = 8'h00;
    logic        I_rdwr = 1'b1;
    logic        I_phy2 = 1'b0;
    logic        O_irq, O_quarter, O_half, O_rd_en;
    logic [7:0]  O_rd_data;

    apu_frame_counter #(
        .CNT_W(16), .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5)
    ) dut (
        .I_clock   (I_clock),
        .I_reset   (I_reset),
        .I_addr    (I_addr),
        .I_wr_data (I_wr_data),
        .I_rdwr    (I_rdwr),
        .I_phy2    (I_phy2),
        .O_irq     (O_irq),
        .O_quarter (O_quarter),
        .O_half    (O_half),
        .O_rd_en   (O_rd_en),
        .O_rd_data (O_rd_data)
    );

    always #10 I_clock = ~I_clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the sequence position is the number of ticks since the
    // sequence (re)started, modulo the mode's period.
    int m_t, m_start, m_mode, m_new, m_inh, m_irq, m_exp;
    bit exp_q, exp_h;
    bit obs_q, obs_h, obs_irq;

    typedef struct {
        logic [15:0] addr;
        logic        rdwr;
        logic        phy2;
        logic        en;
        logic [7:0]  data;
    } dec_vec_t;
    dec_vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (tick %0d)", nm, act, exp, m_t);
        end
    endtask

    function automatic int period();
        return (m_mode != 0 ? S5 : S4) + 1;
    endfunction

    function automatic int pos_at(input int tt);
        return (tt - m_start) % period();
    endfunction

    task automatic model_reset();
        m_t = 0; m_start = 0; m_mode = 0; m_new = 0; m_inh = 0; m_irq = 0; m_exp = 0;
    endtask

    task automatic model_tick(input logic [15:0] a, input logic [7:0] d, input logic rw);
        bit wr, rd, set;
        int pos, fin;
        m_t++;
        wr  = (a == 16'h4017) && !rw;
        rd  = (a == 16'h4015) && rw;
        fin = (m_mode != 0) ? S5 : S4;
        pos = pos_at(m_t);
        set = (m_mode == 0) && !(wr ? d[6] : (m_inh != 0)) &&
              (pos == S4 - 1 || pos == S4 || pos == 0);
        if (m_t == m_exp) begin
            m_start = m_t;
            m_mode  = m_new;
            exp_q   = (m_new != 0);
            exp_h   = (m_new != 0);
            m_exp   = 0;
        end else begin
            exp_q = (pos == S1) || (pos == S2) || (pos == S3) || (pos == fin);
            exp_h = (pos == S2) || (pos == fin);
        end
        if (wr) begin
            m_inh = d[6];
            m_new = d[7];
            m_exp = m_t + ((((m_t - 1) % 2) != 0) ? 4 : 3);
        end
        m_irq = (set || ((m_irq != 0) && !(rd || (wr && d[6])))) ? 1 : 0;
    endtask

    // One CPU cycle: phy2 high for one clock, then low; the tick lands on the
    // rising clock edge after phy2 falls. Entered and left on a falling clock edge.
    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
        I_addr = a; I_wr_data = d; I_rdwr = rw; I_phy2 = 1'b1;
        @(negedge I_clock);
        chk("pulse_width", {O_quarter, O_half}, 2'b00);
        chk("rd_en", O_rd_en, (a == 16'h4015) && rw);
        chk("rd_data", O_rd_data, {1'b0, m_irq[0], 6'b0});
        I_phy2 = 1'b0;
        @(negedge I_clock);
        model_tick(a, d, rw);
        obs_q = O_quarter; obs_h = O_half; obs_irq = O_irq;
        chk("quarter", O_quarter, exp_q);
        chk("half", O_half, exp_h);
        chk("irq", O_irq, m_irq);
    endtask

    task automatic idle();
        cpu_cycle(16'h0000, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        I_reset = 1'b1; I_phy2 = 1'b0; I_addr = 16'h0000; I_rdwr = 1'b1;
        @(negedge I_clock);
        chk("rst_pulses_irq", {O_quarter, O_half, O_irq}, 3'b000);
        chk("rst_rd_data", O_rd_data, 8'h00);
        I_reset = 1'b0;
        model_reset();
    endtask

    // Idle until the next tick has the wanted parity and, optionally, a
    // $4017 write on it would expire at sequence position epos.
    task automatic idle_until(input int par, input int epos);
        int guard;
        bit ok;
        guard = 0;
        forever begin
            ok = ((m_t % 2) == par) &&
                 (epos < 0 || pos_at(m_t + 1 + (par != 0 ? 4 : 3)) == epos);
            if (ok || guard > 4 * (S5 + 1)) break;
            idle();
            guard++;
        end
        chk("idle_bound", ok, 1'b1);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int qt[$];
        int ht[$];
        int qexp[4];
        int hexp[2];
        int rise, first_q, w, e;
        bit seen;
        int r;
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;

        tbl[0] = '{16'h4015, 1'b1, 1'b1, 1'b1, 8'h40};
        tbl[1] = '{16'h4015, 1'b0, 1'b1, 1'b0, 8'h40};
        tbl[2] = '{16'h4015, 1'b1, 1'b0, 1'b0, 8'h40};
        tbl[3] = '{16'h4017, 1'b1, 1'b1, 1'b0, 8'h40};
        tbl[4] = '{16'h4014, 1'b1, 1'b1, 1'b0, 8'h40};
        tbl[5] = '{16'hC015, 1'b1, 1'b1, 1'b0, 8'h40};
        tbl[6] = '{16'h4015, 1'b1, 1'b1, 1'b1, 8'h40};
        qexp = '{S1, S2, S3, S4};
        hexp = '{S2, S4};
        model_reset();

        @(negedge I_clock);
        do_reset();

        // 4-step idle run from reset
        rise = -1;
        for (int i = 0; i < S4 + 2; i++) begin
            idle();
            if (obs_q) qt.push_back(m_t);
            if (obs_h) ht.push_back(m_t);
            if (obs_irq && rise < 0) rise = m_t;
        end
        chk("q_count", qt.size(), 4);
        for (int k = 0; k < 4; k++) chk("q_tick", (k < qt.size()) ? qt[k] : -1, qexp[k]);
        chk("h_count", ht.size(), 2);
        for (int k = 0; k < 2; k++) chk("h_tick", (k < ht.size()) ? ht[k] : -1, hexp[k]);
        chk("irq_rise", rise, S4 - 1);
        chk("irq_held", obs_irq, 1'b1);

        // $4015 decode table, applied between clock edges so no tick occurs
        for (int k = 0; k < 7; k++) begin
            I_addr = tbl[k].addr; I_rdwr = tbl[k].rdwr; I_phy2 = tbl[k].phy2;
            #1;
            chk("tbl_rd_en", O_rd_en, tbl[k].en);
            chk("tbl_rd_data", O_rd_data, tbl[k].data);
        end
        I_phy2 = 1'b0; I_addr = 16'h0000; I_rdwr = 1'b1;

        // Status read clears the IRQ
        cpu_cycle(16'h4015, 8'h00, 1'b1);
        chk("rd_clear", obs_irq, 1'b0);

        // Read landing on STEP4-1: set wins
        idle_until(m_t % 2, -1);
        while (pos_at(m_t + 1) != S4 - 1 && m_t < 4 * S5) idle();
        cpu_cycle(16'h4015, 8'h00, 1'b1);
        chk("set_wins", obs_irq, 1'b1);

        // Inhibit write drops the IRQ at once and keeps it low
        cpu_cycle(16'h4017, 8'h40, 1'b0);
        chk("inh_clear", obs_irq, 1'b0);
        seen = 0;
        for (int i = 0; i < 2 * (S4 + 1) + 5; i++) begin
            idle();
            seen |= obs_irq;
        end
        chk("inh_no_irq", seen, 1'b0);

        // Even-parity switch to 5-step: expiry 3 ticks later with both pulses
        idle_until(0, 5);
        w = m_t + 1;
        cpu_cycle(16'h4017, 8'h80, 1'b0);
        first_q = -1; seen = 0;
        for (int i = 0; i < S5 + 5; i++) begin
            idle();
            if (m_t == w + 3) chk("exp3_pulse", {obs_q, obs_h}, 2'b11);
            if (m_t > w + 3 && obs_q && first_q < 0) first_q = m_t;
            seen |= obs_irq;
        end
        chk("exp3_nextq", first_q, w + 3 + S1);
        chk("mode5_no_irq", seen, 1'b0);

        // Odd-parity write: expiry 4 ticks later
        idle_until(1, -1);
        w = m_t + 1;
        cpu_cycle(16'h4017, 8'h80, 1'b0);
        first_q = -1;
        for (int i = 0; i < S1 + 6; i++) begin
            idle();
            if (m_t == w + 4) chk("exp4_pulse", {obs_q, obs_h}, 2'b11);
            if (m_t > w + 4 && obs_q && first_q < 0) first_q = m_t;
        end
        chk("exp4_nextq", first_q, w + 4 + S1);

        // Expiry to 4-step on the old final step: no leaked final pulses
        idle_until(1, S5);
        w = m_t + 1;
        e = w + 4;
        cpu_cycle(16'h4017, 8'h00, 1'b0);
        first_q = -1; rise = -1;
        for (int i = 0; i < S4 + 6; i++) begin
            idle();
            if (m_t == e) chk("no_leak", {obs_q, obs_h}, 2'b00);
            if (m_t > e && obs_q && first_q < 0) first_q = m_t;
            if (obs_irq && rise < 0) rise = m_t;
        end
        chk("leak_nextq", first_q, e + S1);
        chk("leak_irq_rise", rise, e + S4 - 1);

        // Reset with a pending 5-step write: sequence restarts in 4-step mode
        cpu_cycle(16'h4017, 8'h80, 1'b0);
        do_reset();
        first_q = -1; rise = -1;
        for (int i = 0; i < S4 + 1; i++) begin
            idle();
            if (obs_q && first_q < 0) first_q = m_t;
            if (obs_irq && rise < 0) rise = m_t;
        end
        chk("rst_first_q", first_q, S1);
        chk("rst_irq_rise", rise, S4 - 1);

        // Randomized bus traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            d = 8'($urandom);
            if (r < 3) begin
                a = 16'h4017; rw = 1'b0;
            end else if (r < 8) begin
                a = 16'h4015; rw = 1'b1;
            end else if (r < 10) begin
                a = 16'h4015; rw = 1'b0;
            end else begin
                a = 16'($urandom); rw = 1'($urandom);
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            cpu_cycle(a, d, rw);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
